cache_miss_ctrl: RTL

Miss/refill sequencer for the 2-way writeback cache. On a miss the cache FSM hands one request to this block: an optional dirty-victim writeback and a one-word line fill. The block drives the cache's AXI-Lite manager port to the next memory level and returns the fill word with error status. It replaces the ad-hoc WRITE_BACK_MEM/FETCH_MEM sequencing inside the cache controller with one handshaked unit.

---
 rtl/cache_miss_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/cache_miss_ctrl.sv
// Miss/refill sequencer: optional dirty-victim writeback then a one-word fill over AXI-Lite.
// Optional per-phase watchdog enabled by defining CACHE_MISS_CTRL_TIMEOUT_EN.
module cache_miss_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Miss request from the cache FSM
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wb,
  input  logic [ADDR_WIDTH-1:0] req_wb_addr,
  input  logic [31:0]           req_wb_data,
  input  logic [ADDR_WIDTH-1:0] req_fill_addr,
  // Fill result
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_err,
  // AXI-Lite manager port
  output logic [ADDR_WIDTH-1:0] axil_awaddr_mng,
  output logic                  axil_awvalid_mng,
  input  logic                  axil_awready_mng,
  output logic [31:0]           axil_wdata_mng,
  output logic                  axil_wvalid_mng,
  input  logic                  axil_wready_mng,
  input  logic [1:0]            axil_bresp_mng,
  input  logic                  axil_bvalid_mng,
  output logic                  axil_bready_mng,
  output logic [ADDR_WIDTH-1:0] axil_araddr_mng,
  output logic                  axil_arvalid_mng,
  input  logic                  axil_arready_mng,
  input  logic [31:0]           axil_rdata_mng,
  input  logic [1:0]            axil_rresp_mng,
  input  logic                  axil_rvalid_mng,
  output logic                  axil_rready_mng
);

  typedef enum logic [2:0] {
    StIdle,
    StWbReq,
    StWbResp,
    StRdReq,
    StRdData,
    StResp
  } state_e;

  state_e state_q;

  logic aw_done;
  logic w_done;
  logic busy;
  logic advance;
  logic timeout;

  // Word addresses only; the low byte-offset bits are never forwarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_wb_addr[1:0], req_fill_addr[1:0]};

  // A channel counts as done once its valid has dropped or is being accepted this cycle.
  assign aw_done = !axil_awvalid_mng || axil_awready_mng;
  assign w_done  = !axil_wvalid_mng || axil_wready_mng;

  always_comb begin
    busy    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      StWbReq: begin
        busy    = 1'b1;
        advance = aw_done && w_done;
      end
      StWbResp: begin
        busy    = 1'b1;
        advance = axil_bvalid_mng;
      end
      StRdReq: begin
        busy    = 1'b1;
        advance = axil_arready_mng;
      end
      StRdData: begin
        busy    = 1'b1;
        advance = axil_rvalid_mng;
      end
      default: begin
        busy    = 1'b0;
        advance = 1'b0;
      end
    endcase
  end

`ifdef CACHE_MISS_CTRL_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CntW-1:0] cnt_q;

  // Counter holds the number of completed cycles spent in the current phase.
  assign timeout = busy && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!busy || advance || timeout) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0) ^ busy;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      req_ready        <= 1'b0;
      resp_valid       <= 1'b0;
      resp_data        <= '0;
      resp_err         <= 1'b0;
      axil_awaddr_mng  <= '0;
      axil_awvalid_mng <= 1'b0;
      axil_wdata_mng   <= '0;
      axil_wvalid_mng  <= 1'b0;
      axil_bready_mng  <= 1'b0;
      axil_araddr_mng  <= '0;
      axil_arvalid_mng <= 1'b0;
      axil_rready_mng  <= 1'b0;
    end else if (timeout) begin
      // Abandon the downstream transaction and report the failure to the cache.
      axil_awvalid_mng <= 1'b0;
      axil_wvalid_mng  <= 1'b0;
      axil_bready_mng  <= 1'b0;
      axil_arvalid_mng <= 1'b0;
      axil_rready_mng  <= 1'b0;
      resp_data        <= '0;
      resp_err         <= 1'b1;
      resp_valid       <= 1'b1;
      state_q          <= StResp;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            req_ready       <= 1'b0;
            resp_err        <= 1'b0;
            axil_awaddr_mng <= {req_wb_addr[ADDR_WIDTH-1:2], 2'b00};
            axil_wdata_mng  <= req_wb_data;
            axil_araddr_mng <= {req_fill_addr[ADDR_WIDTH-1:2], 2'b00};
            if (req_wb) begin
              axil_awvalid_mng <= 1'b1;
              axil_wvalid_mng  <= 1'b1;
              state_q          <= StWbReq;
            end else begin
              axil_arvalid_mng <= 1'b1;
              state_q          <= StRdReq;
            end
          end
        end
        StWbReq: begin
          if (axil_awvalid_mng && axil_awready_mng) begin
            axil_awvalid_mng <= 1'b0;
          end
          if (axil_wvalid_mng && axil_wready_mng) begin
            axil_wvalid_mng <= 1'b0;
          end
          if (advance) begin
            axil_bready_mng <= 1'b1;
            state_q         <= StWbResp;
          end
        end
        StWbResp: begin
          if (axil_bvalid_mng) begin
            axil_bready_mng  <= 1'b0;
            axil_arvalid_mng <= 1'b1;
            if (axil_bresp_mng != 2'b00) begin
              resp_err <= 1'b1;
            end
            state_q <= StRdReq;
          end
        end
        StRdReq: begin
          if (axil_arready_mng) begin
            axil_arvalid_mng <= 1'b0;
            axil_rready_mng  <= 1'b1;
            state_q          <= StRdData;
          end
        end
        StRdData: begin
          if (axil_rvalid_mng) begin
            axil_rready_mng <= 1'b0;
            resp_data       <= axil_rdata_mng;
            resp_valid      <= 1'b1;
            if (axil_rresp_mng != 2'b00) begin
              resp_err <= 1'b1;
            end
            state_q <= StResp;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
